nr_divider_param: RTL and testbench
===================================

Name: nr_divider_param

Overview:
Parametrised sequential non-restoring divider. Successor to the fixed 4-bit division core. Adds:
- configurable operand width
- a per-operation signed/unsigned mode
- divide-by-zero and signed-overflow flags
- a busy/done handshake
- registered quotient and remainder, so the display top-level or any other consumer can read them directly.

Parameters:
WIDTH, 8, operand/quotient/remainder width in bits (legal range 2..32).
SIGNED_EN, 1, 1 = signed_mode port honoured; 0 = signed_mode ignored and the block is unsigned only.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only when busy=0.
signed_mode  input  1  1 = two's-complement operands (when SIGNED_EN=1); sampled with start.
dividend  input  WIDTH  dividend; sampled with start.
divisor  input  WIDTH  divisor; sampled with start.
busy  output  1  high from the sampling edge until the result is registered.
done  output  1  one-cycle pulse when results update.
quotient  output  WIDTH  result quotient; held until the next completion.
remainder  output  WIDTH  result remainder; held until the next completion.
div_by_zero  output  1  last operation had divisor==0.
overflow  output  1  last operation was signed MIN/-1.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE; busy, done, quotient, remainder, div_by_zero and overflow all 0; internal A, Q, M and the iteration counter all 0. Reset mid-operation aborts with no done pulse.
- States: IDLE, RUN, FIX.
- IDLE, start=1 at edge E0:
  - Latch operand magnitudes. In signed mode with a negative operand, take its two's complement; MIN stays 2^(WIDTH-1) as an unsigned magnitude.
  - Latch sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
  - Set A (WIDTH+1 bits) = 0, Q = |dividend|, M = |divisor|, counter = WIDTH; busy<=1.
  - Divisor==0: go to FIX directly with the dz flag set.
  - Otherwise go to RUN.
- RUN, one iteration per edge, WIDTH iterations (edges E1..E_WIDTH):
  - Shift {A,Q} left by 1.
  - If old A >= 0, A = A - M; else A = A + M.
  - Q[0] = ~A[WIDTH] (the new sign bit).
  - Decrement counter; at 0 go to FIX.
- FIX, one edge:
  - If A < 0, A = A + M.
  - Negate Q if sign_q; negate A[WIDTH-1:0] if sign_r (signed mode only).
  - Register quotient and remainder, pulse done=1, busy<=0, go to IDLE.
- Latency:
  - Normal operation: done high after edge E_(WIDTH+1).
  - Divide-by-zero: done high after edge E1.
- Divide-by-zero result: quotient = all ones, remainder = dividend unmodified, div_by_zero=1, overflow=0.
- Signed overflow (dividend = -2^(WIDTH-1), divisor = -1, signed mode):
  - quotient = -2^(WIDTH-1), the wrapped bit pattern 100..0.
  - remainder = 0, overflow=1.
  - Full-length operation, no early exit.
- Flags update only on done and hold until the next completion.
- Sign convention: truncation toward zero. Remainder carries the dividend's sign, and |remainder| < |divisor|.
- start while busy=1 is ignored, and operand changes while busy=1 have no effect.
- start in the same cycle done=1 is accepted, because the state is already IDLE. Back-to-back operations therefore have no idle gap.
- SIGNED_EN=0: signed_mode is treated as 0 and overflow stays 0.

Test Plan:
1. WIDTH=4, unsigned 15/15 then 7/2 -> q=1 r=0, then q=3 r=1. Each done pulse is exactly 1 cycle, 5 edges after the start edge; busy is high for those 5 cycles.
2. WIDTH=8, signed -7/2 (0xF9/0x02) -> q=0xFD (-3), r=0xFF (-1); unsigned 0xF9/0x02 -> q=0x7C, r=0x01.
3. WIDTH=8, 200/0 -> done after 1 edge, q=0xFF, r=0xC8, div_by_zero=1. The following 9/2 clears the flag: q=4, r=1.
4. WIDTH=8, signed 0x80/0xFF -> q=0x80, r=0x00, overflow=1. Signed 0x80/0x01 -> q=0x80, overflow=0.
5. Assert rst for 1 cycle at iteration 3 of 15/4 -> all outputs 0 immediately (asynchronous), no done. A new 15/4 afterwards -> q=3, r=3.
6. Hold start=1 continuously with 8/3, changing operands mid-operation -> extra starts are ignored while busy. The next operation launches in the done cycle; results are q=2 r=2, then the new operands' result, with no idle gap between.

Source files
------------

// File: rtl/nr_divider_param.sv
// Sequential non-restoring divider, WIDTH-bit operands.
// Optional two's-complement mode, divide-by-zero and overflow flags.
module nr_divider_param #(
  parameter int WIDTH     = 8,
  parameter int SIGNED_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t state, state_n;

  logic [WIDTH:0]   a, a_n;
  logic [WIDTH-1:0] q, q_n;
  logic [WIDTH-1:0] m, m_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             sq, sq_n;
  logic             sr, sr_n;
  logic             dzp, dzp_n;
  logic             ovp, ovp_n;
  logic             busy_n, done_n;
  logic [WIDTH-1:0] quo_n, rem_n;
  logic             dz_n, ov_n;

  logic             sm;
  logic             negd, negs;
  logic [WIDTH-1:0] magd, mags;
  logic [WIDTH:0]   shifted, na;
  logic [WIDTH-1:0] afix;

  assign sm   = signed_mode & (SIGNED_EN != 0);
  assign negd = sm & dividend[WIDTH-1];
  assign negs = sm & divisor[WIDTH-1];
  assign magd = negd ? (~dividend + 1'b1) : dividend;
  assign mags = negs ? (~divisor + 1'b1) : divisor;

  assign shifted = {a[WIDTH-1:0], q[WIDTH-1]};
  assign na      = a[WIDTH] ? (shifted + {1'b0, m})
                            : (shifted - {1'b0, m});
  assign afix    = a[WIDTH] ? (a[WIDTH-1:0] + m) : a[WIDTH-1:0];

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      a           <= '0;
      q           <= '0;
      m           <= '0;
      cnt         <= '0;
      sq          <= 1'b0;
      sr          <= 1'b0;
      dzp         <= 1'b0;
      ovp         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_n;
      a           <= a_n;
      q           <= q_n;
      m           <= m_n;
      cnt         <= cnt_n;
      sq          <= sq_n;
      sr          <= sr_n;
      dzp         <= dzp_n;
      ovp         <= ovp_n;
      busy        <= busy_n;
      done        <= done_n;
      quotient    <= quo_n;
      remainder   <= rem_n;
      div_by_zero <= dz_n;
      overflow    <= ov_n;
    end
  end

  // Next-state, iteration step and result fix-up
  always_comb begin
    state_n = state;
    a_n     = a;
    q_n     = q;
    m_n     = m;
    cnt_n   = cnt;
    sq_n    = sq;
    sr_n    = sr;
    dzp_n   = dzp;
    ovp_n   = ovp;
    busy_n  = busy;
    done_n  = 1'b0;
    quo_n   = quotient;
    rem_n   = remainder;
    dz_n    = div_by_zero;
    ov_n    = overflow;
    unique case (state)
      IDLE: begin
        if (start) begin
          a_n    = '0;
          q_n    = magd;
          m_n    = mags;
          cnt_n  = CW'(WIDTH);
          sq_n   = negd ^ negs;
          sr_n   = negd;
          dzp_n  = (divisor == '0);
          ovp_n  = sm & (dividend == MINV) & (divisor == ONES);
          busy_n = 1'b1;
          state_n = (divisor == '0) ? FIX : RUN;
        end
      end
      RUN: begin
        a_n   = na;
        q_n   = {q[WIDTH-2:0], ~na[WIDTH]};
        cnt_n = cnt - 1'b1;
        if (cnt == CW'(1)) state_n = FIX;
      end
      FIX: begin
        a_n = {1'b0, afix};
        if (dzp) begin
          // q still holds |dividend|; undo the magnitude to return it raw
          quo_n = ONES;
          rem_n = sr ? (~q + 1'b1) : q;
        end else begin
          quo_n = sq ? (~q + 1'b1) : q;
          rem_n = sr ? (~afix + 1'b1) : afix;
        end
        dz_n    = dzp;
        ov_n    = ovp;
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_nr_divider_param.sv
// Directed bench for nr_divider_param.
// Runs a 4-bit and an 8-bit instance side by side.
module tb_nr_divider_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       s4, sm4, s8, sm8;
  logic [3:0] a4, b4, q4, r4;
  logic [7:0] a8, b8, q8, r8;
  logic       busy4, done4, dz4, ov4;
  logic       busy8, done8, dz8, ov8;

  int nchk  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  nr_divider_param #(.WIDTH(4), .SIGNED_EN(1)) u4 (
    .clk(clk), .rst(rst), .start(s4), .signed_mode(sm4),
    .dividend(a4), .divisor(b4), .busy(busy4), .done(done4),
    .quotient(q4), .remainder(r4), .div_by_zero(dz4),
    .overflow(ov4)
  );

  nr_divider_param #(.WIDTH(8), .SIGNED_EN(1)) u8 (
    .clk(clk), .rst(rst), .start(s8), .signed_mode(sm8),
    .dividend(a8), .divisor(b8), .busy(busy8), .done(done8),
    .quotient(q8), .remainder(r8), .div_by_zero(dz8),
    .overflow(ov8)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for done; n = edges after the start edge
  task automatic wait_done(input bit w8, output int n,
                           output int bc);
    n  = 0;
    bc = 0;
    while (!(w8 ? done8 : done4) && n < 40) begin
      if (w8 ? busy8 : busy4) bc++;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic op(input string tag, input bit w8,
                    input logic sm,
                    input logic [7:0] dd, input logic [7:0] dv,
                    input int lat,
                    input logic [7:0] eq, input logic [7:0] er,
                    input logic edz, input logic eov);
    int n, bc;
    @(negedge clk);
    if (w8) begin
      s8 = 1'b1; sm8 = sm; a8 = dd; b8 = dv;
    end else begin
      s4 = 1'b1; sm4 = sm; a4 = dd[3:0]; b4 = dv[3:0];
    end
    @(posedge clk); #1;
    s4 = 1'b0;
    s8 = 1'b0;
    wait_done(w8, n, bc);
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_busy"}, bc, lat);
    if (w8) begin
      chk({tag, "_q"}, q8, eq);
      chk({tag, "_r"}, r8, er);
      chk({tag, "_dz"}, dz8, edz);
      chk({tag, "_ov"}, ov8, eov);
    end else begin
      chk({tag, "_q"}, q4, eq);
      chk({tag, "_r"}, r4, er);
      chk({tag, "_dz"}, dz4, edz);
      chk({tag, "_ov"}, ov4, eov);
    end
    @(posedge clk); #1;
    chk({tag, "_pulse"}, w8 ? done8 : done4, 1'b0);
  endtask

  initial begin
    int n, bc, seen;
    rst = 1'b1;
    s4 = 0; sm4 = 0; a4 = 0; b4 = 0;
    s8 = 0; sm8 = 0; a8 = 0; b8 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy8, 1'b0);
    chk("rst_done", done8, 1'b0);
    chk("rst_q", q8, 8'h00);
    chk("rst_r", r8, 8'h00);
    chk("rst_flags", {dz8, ov8, dz4, ov4}, 4'h0);
    @(negedge clk);
    rst = 1'b0;

    op("u15_15", 0, 0, 8'h0F, 8'h0F, 5, 8'h01, 8'h00, 0, 0);
    op("u7_2",   0, 0, 8'h07, 8'h02, 5, 8'h03, 8'h01, 0, 0);

    op("sm7_2",  1, 1, 8'hF9, 8'h02, 9, 8'hFD, 8'hFF, 0, 0);
    op("u249_2", 1, 0, 8'hF9, 8'h02, 9, 8'h7C, 8'h01, 0, 0);
    op("s7_m2",  1, 1, 8'h07, 8'hFE, 9, 8'hFD, 8'h01, 0, 0);
    op("sm7_m2", 1, 1, 8'hF9, 8'hFE, 9, 8'h03, 8'hFF, 0, 0);

    op("u200_0", 1, 0, 8'hC8, 8'h00, 1, 8'hFF, 8'hC8, 1, 0);
    op("u9_2",   1, 0, 8'h09, 8'h02, 9, 8'h04, 8'h01, 0, 0);
    op("sm7_0",  1, 1, 8'hF9, 8'h00, 1, 8'hFF, 8'hF9, 1, 0);

    op("smin_m1", 1, 1, 8'h80, 8'hFF, 9, 8'h80, 8'h00, 0, 1);
    op("smin_1",  1, 1, 8'h80, 8'h01, 9, 8'h80, 8'h00, 0, 0);

    // Asynchronous reset during iteration 3 of 15/4
    @(negedge clk);
    s8 = 1; sm8 = 0; a8 = 8'd15; b8 = 8'd4;
    @(posedge clk); #1;
    s8 = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy8, 1'b0);
    chk("arst_q", q8, 8'h00);
    chk("arst_r", r8, 8'h00);
    chk("arst_ov", ov8, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8) seen++;
    end
    chk("arst_nodone", seen, 0);
    op("u15_4", 1, 0, 8'h0F, 8'h04, 9, 8'h03, 8'h03, 0, 0);

    // start held high, operands changed while busy
    @(negedge clk);
    s8 = 1; sm8 = 0; a8 = 8'd8; b8 = 8'd3;
    @(posedge clk); #1;
    a8 = 8'd100;
    b8 = 8'd7;
    wait_done(1, n, bc);
    chk("b2b_lat1", n, 9);
    chk("b2b_q1", q8, 8'h02);
    chk("b2b_r1", r8, 8'h02);
    @(posedge clk); #1;
    chk("b2b_gap", {done8, busy8}, 2'b01);
    s8 = 0;
    wait_done(1, n, bc);
    chk("b2b_lat2", n, 9);
    chk("b2b_q2", q8, 8'd14);
    chk("b2b_r2", r8, 8'd2);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
